// File: rtl/iic_cfg_seq.sv
// -----------------------------------------------------------------------------
// iic_cfg_seq
//
// Walks a small configuration table and hands each entry to an external IIC
// write engine, one register write at a time. A failed write (NACK or no
// answer within TIMEOUT cycles) is retried up to MAX_RETRY extra times. If an
// entry still fails after that, the sequence stops with err set. Consecutive
// write attempts are separated by GAP_CYC idle cycles.
//
// Ports
//   s_clk     system clock, rising edge
//   s_rst     synchronous, active-high reset
//   start     one-cycle pulse that launches a sequence (only honoured in IDLE)
//   busy      high from the cycle after start is accepted through the FIN cycle
//   done      one-cycle pulse at the end of a sequence (success or failure)
//   err       sticky failure flag, cleared by the next accepted start
//   cfg_idx   index of the current table entry (drives an external lookup)
//   cfg_data  table word for cfg_idx: [15:8] register address, [7:0] data
//   wr_req    one-cycle write request to the engine
//   wr_addr   register address for the engine, stable between LOADs
//   wr_data   register data for the engine, stable between LOADs
//   wr_done   one-cycle pulse from the engine: transaction finished
//   wr_nack   qualified by wr_done; 1 = slave did not acknowledge
// -----------------------------------------------------------------------------
module iic_cfg_seq #(
  parameter int CFG_NUM   = 8,
  parameter int GAP_CYC   = 100,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 50000
) (
  input  logic        s_clk,
  input  logic        s_rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  cfg_idx,
  input  logic [15:0] cfg_data,
  output logic        wr_req,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  input  logic        wr_done,
  input  logic        wr_nack
);

  // Counter widths are chosen so each counter can hold its own limit.
  localparam int TO_W  = (TIMEOUT > 1)   ? $clog2(TIMEOUT + 1)   : 1;
  localparam int GAP_W = (GAP_CYC > 1)   ? $clog2(GAP_CYC + 1)   : 1;
  localparam int RT_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  // GAP_CYC of 0 still spends one cycle in GAP; the state cannot be skipped.
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [RT_W-1:0]  RT_MAX   = RT_W'(MAX_RETRY);
  localparam logic [3:0]       IDX_LAST = 4'(CFG_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_WAIT,
    S_GAP,
    S_FIN
  } state_e;

  state_e           state_q,   state_d;
  logic [3:0]       cfg_idx_q, cfg_idx_d;
  logic [RT_W-1:0]  retry_q,   retry_d;
  logic [TO_W-1:0]  to_cnt_q,  to_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]       wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             err_q,     err_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             wr_req_q,  wr_req_d;

  logic             attempt_ok;
  logic             attempt_fail;

  always_comb begin
    // NOTE: every variable written here gets its current value first, so no
    // path through the case can leave one unassigned and infer a latch.
    state_d      = state_q;
    cfg_idx_d    = cfg_idx_q;
    retry_d      = retry_q;
    to_cnt_d     = to_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    err_d        = err_q;
    attempt_ok   = 1'b0;
    attempt_fail = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          cfg_idx_d = '0;
          retry_d   = '0;
          err_d     = 1'b0;
        end
      end

      S_LOAD: begin
        wr_addr_d = cfg_data[15:8];
        wr_data_d = cfg_data[7:0];
        state_d   = S_REQ;
      end

      S_REQ: begin
        to_cnt_d = '0;
        state_d  = S_WAIT;
      end

      S_WAIT: begin
        // An engine answer in the limit cycle wins over the timeout.
        if (wr_done) begin
          attempt_ok   = !wr_nack;
          attempt_fail = wr_nack;
        end else if (to_cnt_q >= TO_LAST) begin
          attempt_fail = 1'b1;
        end else if (to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end

        if (attempt_ok) begin
          retry_d = '0;
          if (cfg_idx_q == IDX_LAST) begin
            state_d = S_FIN;
          end else begin
            cfg_idx_d = cfg_idx_q + 4'd1;
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end
        end else if (attempt_fail) begin
          if (retry_q < RT_MAX) begin
            // Retry the same entry after the gap.
            retry_d   = retry_q + RT_W'(1);
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end else begin
            // Retries exhausted: stop here, cfg_idx points at the bad entry.
            err_d   = 1'b1;
            state_d = S_FIN;
          end
        end
      end

      S_GAP: begin
        if (gap_cnt_q >= GAP_LAST) begin
          state_d = S_LOAD;
        end else if (gap_cnt_q != '1) begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Moore outputs are registered from the next state, so they line up
    // exactly with the state they belong to.
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_FIN);
    wr_req_d = (state_d == S_REQ);
  end

  always_ff @(posedge s_clk) begin
    // NOTE: non-blocking assignments here make every register update from the
    // values present before the edge, independent of statement order.
    if (s_rst) begin
      state_q   <= S_IDLE;
      cfg_idx_q <= '0;
      retry_q   <= '0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_req_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_idx_q <= cfg_idx_d;
      retry_q   <= retry_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_req_q  <= wr_req_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign cfg_idx = cfg_idx_q;
  assign wr_req  = wr_req_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_iic_cfg_seq.sv
// -----------------------------------------------------------------------------
// tb_iic_cfg_seq
//
// Drives iic_cfg_seq with a table of {8'h10+i, 8'hA0+i} and an engine model
// that answers each request after a programmable latency, NACKs or stays
// silent on a chosen number of attempts per entry. Expected request lists,
// request cycles, finish cycle, err and final cfg_idx are derived from the
// per-entry failure plan with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_iic_cfg_seq;

  localparam int CFG_NUM   = 4;
  localparam int GAP_CYC   = 4;
  localparam int MAX_RETRY = 2;
  localparam int TIMEOUT   = 64;

  logic        s_clk = 1'b0;
  logic        s_rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  cfg_idx;
  logic [15:0] cfg_data;
  logic        wr_req;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_done;
  logic        wr_nack;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Failure plan: entry i fails its first fails[i] attempts, by NACK or, if
  // silent[i], by never answering.
  int  fails  [CFG_NUM];
  bit  silent [CFG_NUM];
  int  att    [CFG_NUM];
  int  lat      = 10;
  int  eng_cnt  = 0;
  bit  eng_nack = 1'b0;

  logic [15:0] req_q[$];
  int          req_cyc_q[$];
  int          done_cnt = 0;

  iic_cfg_seq #(
    .CFG_NUM   (CFG_NUM),
    .GAP_CYC   (GAP_CYC),
    .MAX_RETRY (MAX_RETRY),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .s_clk    (s_clk),
    .s_rst    (s_rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cfg_idx  (cfg_idx),
    .cfg_data (cfg_data),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_done  (wr_done),
    .wr_nack  (wr_nack)
  );

  always #5 s_clk = ~s_clk;
  always @(posedge s_clk) cyc <= cyc + 1;

  assign cfg_data = {8'h10 + {4'h0, cfg_idx}, 8'hA0 + {4'h0, cfg_idx}};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    req_q.delete();
    req_cyc_q.delete();
    done_cnt = 0;
    for (int i = 0; i < CFG_NUM; i++) att[i] = 0;
  endtask

  // Engine model and monitor, evaluated on the falling edge.
  initial begin
    int idx;
    wr_done = 1'b0;
    wr_nack = 1'b0;
    forever begin
      @(negedge s_clk);
      wr_done = 1'b0;
      wr_nack = 1'b0;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          wr_done = 1'b1;
          wr_nack = eng_nack;
        end
      end
      if (done === 1'b1) done_cnt++;
      if (wr_req === 1'b1) begin
        req_q.push_back({wr_addr, wr_data});
        req_cyc_q.push_back(cyc);
        idx = int'(wr_addr) - 'h10;
        if (idx >= 0 && idx < CFG_NUM) begin
          att[idx]++;
          if (att[idx] <= fails[idx]) begin
            if (!silent[idx]) begin
              eng_cnt  = lat;
              eng_nack = 1'b1;
            end
          end else begin
            eng_cnt  = lat;
            eng_nack = 1'b0;
          end
        end
      end
    end
  end

  // One full sequence under the current failure plan.
  task automatic run_seq(input string name, input int lat_i, input bit mid_start);
    logic [15:0] exp_q[$];
    int          exp_cyc[$];
    int          t0, t, w, last_t, last_w, attempts, n, fin_cyc, exp_idx;
    bit          exp_err, aborted;
    logic        fin_err;
    logic [3:0]  fin_idx;

    // Reference: attempts per entry from the plan, cycle of each request
    // from the REQ + WAIT + GAP + LOAD period of the preceding attempt.
    t       = 0;
    exp_err = 1'b0;
    exp_idx = CFG_NUM - 1;
    aborted = 1'b0;
    last_t  = 0;
    last_w  = 0;
    for (int i = 0; i < CFG_NUM && !aborted; i++) begin
      attempts = (fails[i] > MAX_RETRY) ? MAX_RETRY + 1 : fails[i] + 1;
      for (int a = 0; a < attempts; a++) begin
        w = (a < fails[i] && silent[i]) ? TIMEOUT : lat_i;
        exp_q.push_back({8'h10 + 8'(i), 8'hA0 + 8'(i)});
        exp_cyc.push_back(t);
        last_t = t;
        last_w = w;
        t = t + 1 + w + GAP_CYC + 1;
      end
      if (fails[i] > MAX_RETRY) begin
        aborted = 1'b1;
        exp_err = 1'b1;
        exp_idx = i;
      end
    end

    clear_log();
    lat = lat_i;
    @(negedge s_clk);
    start = 1'b1;
    t0    = cyc;
    @(negedge s_clk);
    start = 1'b0;
    check({name, " load busy"}, busy, 1);
    check({name, " load err"}, err, 0);
    check({name, " load wr_req"}, wr_req, 0);

    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge s_clk);
      n++;
      start = mid_start && ((cyc - t0 == 20) || (cyc - t0 == 45) || done === 1'b1);
    end
    check({name, " done seen"}, done, 1);
    fin_cyc = cyc;
    fin_err = err;
    fin_idx = cfg_idx;
    @(negedge s_clk);
    start = 1'b0;
    check({name, " done pulse"}, done, 0);
    check({name, " busy drop"}, busy, 0);
    repeat (8) @(negedge s_clk);
    check({name, " stays idle"}, busy, 0);
    check({name, " done count"}, done_cnt, 1);
    check({name, " err sticky"}, err, exp_err);

    check({name, " req count"}, req_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < req_q.size(); i++) begin
      check($sformatf("%s req%0d addr/data", name, i), req_q[i], exp_q[i]);
      check($sformatf("%s req%0d cycle", name, i), req_cyc_q[i] - t0, exp_cyc[i] + 2);
    end
    check({name, " fin cycle"}, fin_cyc - t0, last_t + 2 + last_w + 1);
    check({name, " fin err"}, fin_err, exp_err);
    check({name, " fin cfg_idx"}, fin_idx, exp_idx);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " busy"}, busy, 0);
    check({name, " done"}, done, 0);
    check({name, " err"}, err, 0);
    check({name, " wr_req"}, wr_req, 0);
    check({name, " cfg_idx"}, cfg_idx, 0);
    check({name, " wr_addr"}, wr_addr, 0);
    check({name, " wr_data"}, wr_data, 0);
  endtask

  initial begin
    int n;
    s_rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < CFG_NUM; i++) begin
      fails[i]  = 0;
      silent[i] = 1'b0;
    end

    repeat (3) @(negedge s_clk);
    check_reset_outputs("por");
    s_rst = 1'b0;
    repeat (5) @(negedge s_clk);
    check("por idle busy", busy, 0);
    check("por no req", req_q.size(), 0);

    run_seq("nominal", 10, 1'b0);

    fails[1] = 1;
    run_seq("nack1_once", 10, 1'b0);
    fails[1] = 0;

    fails[2] = 3;
    run_seq("nack2_always", 10, 1'b0);
    fails[2] = 0;

    fails[0]  = 3;
    silent[0] = 1'b1;
    run_seq("silent0", 10, 1'b0);
    fails[0]  = 0;
    silent[0] = 1'b0;

    // Answer lands in the same cycle as the timeout limit.
    run_seq("done_at_limit", TIMEOUT, 1'b0);

    run_seq("mid_start", 10, 1'b1);

    // Reset while waiting on entry 1.
    clear_log();
    lat = 10;
    @(negedge s_clk);
    start = 1'b1;
    @(negedge s_clk);
    start = 1'b0;
    n = 0;
    while (req_q.size() < 2 && n < 500) begin
      @(negedge s_clk);
      n++;
    end
    check("rst second req seen", (req_q.size() >= 2), 1);
    repeat (3) @(negedge s_clk);
    check("rst pre cfg_idx", cfg_idx, 1);
    check("rst pre busy", busy, 1);
    s_rst = 1'b1;
    @(negedge s_clk);
    check_reset_outputs("rst in wait");
    eng_cnt = 0;
    @(negedge s_clk);
    s_rst = 1'b0;
    repeat (10) @(negedge s_clk);
    check("rst idle busy", busy, 0);
    check("rst no new req", req_q.size(), 2);
    run_seq("after_rst", 10, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < CFG_NUM; i++) begin
        fails[i]  = ($urandom_range(0, 5) == 0) ? 3 : int'($urandom_range(0, 2));
        silent[i] = ($urandom_range(0, 3) == 0);
      end
      run_seq($sformatf("rand%0d", r), int'($urandom_range(1, 20)), r[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iic_cfg_seq.md
IIC_CFG_SEQ -- requirements
Module: iic_cfg_seq

Interface
REQ-001 Parameter CFG_NUM, default 8, number of configuration entries written per sequence (1..16).
REQ-002 Parameter GAP_CYC, default 100, idle s_clk cycles inserted between consecutive write transactions.
REQ-003 Parameter MAX_RETRY, default 3, extra attempts allowed per entry after a failed attempt.
REQ-004 Parameter TIMEOUT, default 50000, s_clk cycles in WAIT before an attempt is declared failed.
REQ-005 s_clk  input  1  system clock; all logic on rising edge.
REQ-006 s_rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse that launches a configuration sequence.
REQ-008 busy  output  1  high from the cycle after start is accepted until the FIN cycle ends.
REQ-009 done  output  1  one-cycle pulse at sequence end, success or failure.
REQ-010 err  output  1  sticky failure flag; cleared on the next accepted start.
REQ-011 cfg_idx  output  4  index of the current table entry, driving an external lookup table.
REQ-012 cfg_data  input  16  table word for cfg_idx: [15:8] register address, [7:0] register data.
REQ-013 wr_req  output  1  one-cycle pulse requesting one write from the IIC write engine.
REQ-014 wr_addr  output  8  register address presented to the engine; stable from LOAD until the next LOAD.
REQ-015 wr_data  output  8  register data presented to the engine; stable from LOAD until the next LOAD.
REQ-016 wr_done  input  1  one-cycle pulse from the engine: transaction finished.
REQ-017 wr_nack  input  1  qualified by wr_done; 1 = slave did not acknowledge.

Function
REQ-018 States SHALL be IDLE, LOAD, REQ, WAIT, GAP, FIN, and all outputs SHALL be registered/Moore.
REQ-019 IDLE: on start=1 -> LOAD; cfg_idx, retry counter and err cleared to 0 in the same edge.
REQ-020 LOAD: lasts 1 cycle; cfg_data is sampled into wr_addr/wr_data at the end of the cycle; then -> REQ.
REQ-021 REQ: wr_req=1 for exactly this 1 cycle; the timeout counter clears; then -> WAIT.
REQ-022 wr_req SHALL first rise 2 cycles after the cycle in which start is sampled.
REQ-023 WAIT, wr_done=1 and wr_nack=0: retry counter <- 0; if cfg_idx=CFG_NUM-1 -> FIN, else cfg_idx increments and -> GAP.
REQ-024 WAIT, failure: the cycle has wr_done=1 with wr_nack=1, or the timeout counter reaches TIMEOUT-1 with no wr_done.
REQ-025 On failure with retry counter < MAX_RETRY: retry counter increments, cfg_idx is unchanged, -> GAP.
REQ-026 On failure with retry counter = MAX_RETRY: err <- 1, cfg_idx is held, -> FIN; total attempts for the entry = MAX_RETRY+1.
REQ-027 GAP: counts GAP_CYC cycles, then -> LOAD.
REQ-028 FIN: done=1 for 1 cycle, busy=0 from the following cycle; -> IDLE.
REQ-029 start SHALL be ignored in every state except IDLE, with no effect on counters or outputs.
REQ-030 wr_done SHALL be ignored outside WAIT; wr_nack SHALL be ignored when wr_done=0.
REQ-031 wr_done arriving in the same cycle as the timeout limit SHALL take priority over the timeout.
REQ-032 The timeout counter SHALL be wide enough for TIMEOUT and SHALL saturate rather than wrap.
REQ-033 The GAP counter SHALL be wide enough for GAP_CYC and SHALL saturate rather than wrap.

Reset
REQ-034 s_rst=1 at a clock edge SHALL force IDLE, from any state including WAIT or GAP.
REQ-035 Reset values: busy=0, done=0, err=0, wr_req=0, cfg_idx=0, wr_addr=0, wr_data=0, all counters 0.
REQ-036 After reset is released, the block SHALL act only on a new start pulse.

Verification
Bench parameters: CFG_NUM=4, GAP_CYC=4, MAX_RETRY=2, TIMEOUT=64; table entry i = {8'h10+i, 8'hA0+i}; engine model answers wr_done 10 cycles after wr_req.
REQ-037 Nominal run, all ACK -> 4 wr_req pulses carrying addr/data 10/A0, 11/A1, 12/A2, 13/A3; at least 4 idle cycles between a wr_done and the next wr_req; one done pulse; err=0.
REQ-038 Entry 1 NACKed once -> entry 1 (11/A1) requested twice, 5 wr_req pulses total, done with err=0.
REQ-039 Entry 2 NACKed on every attempt -> exactly 3 requests of 12/A2, none of 13/A3; done=1 with err=1; cfg_idx holds 2.
REQ-040 Engine silent on entry 0 -> a retry wr_req every 64+4+2 cycles, 3 attempts total, then done with err=1.
REQ-041 start pulsed mid-sequence -> no effect on the sequence; s_rst in WAIT -> IDLE next edge with all outputs at reset values; a new start then runs the nominal sequence from entry 0.
